pipe_hazard_ctrl: RTL and testbench

- Pipeline control unit for the 5-stage 32-bit MIPS core.
- Generates the per-stage enable and flush signals for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC enable.
- Sequences three events:
  - load-use bubbles;
  - taken-branch flushes;
  - multi-cycle data-memory waits, with timeout recovery.
- Sits beside the pipeline registers; it carries no datapath values.

---
 rtl/pipe_ctrl_pkg.sv | 44 ++++
 rtl/load_use_detect.sv | 21 ++
 rtl/pipe_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control slice: state encoding, register
// address constants and the control-vector bundle driven to the pipeline registers.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MEM_ERR  = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
        logic mem_err;
    } ctrl_t;

    // Control for a non-frozen cycle: taken branch outranks load-use because
    // the ID instruction that would cause the bubble is squashed anyway.
    function automatic ctrl_t run_ctrl(input logic branch_taken, input logic lu);
        ctrl_t c;
        c = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
              mem_wb_en: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0,
              mem_wb_flush: 1'b0, mem_err: 1'b0};
        if (branch_taken) begin
            c.if_id_flush = 1'b1;
            c.id_ex_flush = 1'b1;
        end else if (lu) begin
            c.pc_en       = 1'b0;
            c.if_id_en    = 1'b0;
            c.id_ex_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection between the load in EX and the
// source operands of the instruction in ID. Register 0 never hazards.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    output logic                  lu_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rd_i == id_rs_i);
    assign rt_match = id_uses_rt_i && (ex_rd_i == id_rt_i);
    assign lu_o     = ex_mem_read_i && (ex_rd_i != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline enable/flush sequencer: load-use bubbles, taken-branch squashes and
// frozen multi-cycle memory waits with timeout abort. Outputs are Mealy.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  mem_wb_flush,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int TCNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic                lu;
    logic                ms;
    ctrl_t               ctrl;

    load_use_detect u_lu (
        .ex_mem_read_i (ex_mem_read),
        .ex_rd_i       (ex_rd),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_uses_rt_i  (id_uses_rt),
        .lu_o          (lu)
    );

    assign ms = mem_req && !mem_ready;

    always_comb begin
        ctrl    = run_ctrl(ex_branch_taken, lu);
        state_d = state_q;
        tcnt_d  = tcnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (ms) begin
                    ctrl    = '0;
                    state_d = ST_MEM_WAIT;
                    tcnt_d  = TCNT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = ST_RUN;
                    tcnt_d  = '0;
                end else begin
                    ctrl = '0;
                    if (tcnt_q == TCNT_LAST) begin
                        state_d = ST_MEM_ERR;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end
            ST_MEM_ERR: begin
                // The aborted access must not reach the register file.
                ctrl.mem_wb_flush = 1'b1;
                ctrl.mem_err      = 1'b1;
                state_d           = ST_RUN;
                tcnt_d            = '0;
            end
            default: begin
                state_d = ST_RUN;
                tcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!ctrl.pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            tcnt_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Reset forces a safe pipeline immediately, independent of the clock.
    assign pc_en        = !reset && ctrl.pc_en;
    assign if_id_en     = !reset && ctrl.if_id_en;
    assign id_ex_en     = !reset && ctrl.id_ex_en;
    assign ex_mem_en    = !reset && ctrl.ex_mem_en;
    assign mem_wb_en    = !reset && ctrl.mem_wb_en;
    assign if_id_flush  = reset || ctrl.if_id_flush;
    assign id_ex_flush  = reset || ctrl.id_ex_flush;
    assign mem_wb_flush = reset || ctrl.mem_wb_flush;
    assign mem_err      = !reset && ctrl.mem_err;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with TIMEOUT=4 and a 4-bit stall counter
// so that both the timeout path and counter saturation are reachable quickly.
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    // Vector order: pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, mem_wb flushes, mem_err
    localparam logic [8:0] V_RUN   = 9'b1_1111_000_0;
    localparam logic [8:0] V_FROZE = 9'b0_0000_000_0;
    localparam logic [8:0] V_LU    = 9'b0_0111_010_0;
    localparam logic [8:0] V_BR    = 9'b1_1111_110_0;
    localparam logic [8:0] V_RST   = 9'b0_0000_111_0;
    localparam logic [8:0] V_ERR   = 9'b1_1111_001_1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs, id_rt, ex_rd;
    logic             id_uses_rt, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [8:0]       ctrl_vec;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mem_wb_flush    (mem_wb_flush),
        .mem_err         (mem_err),
        .stall_cnt       (stall_cnt)
    );

    assign ctrl_vec = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                       if_id_flush, id_ex_flush, mem_wb_flush, mem_err};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 5'd0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Called at posedge+1 with inputs set: checks Mealy outputs mid-cycle,
    // then the stall counter just after the following edge.
    task automatic step(input string tag, input logic [8:0] exp_vec, input int exp_cnt);
        #3;
        chk({tag, ".ctrl"}, 32'(ctrl_vec), 32'(exp_vec));
        @(posedge clk);
        #1;
        chk({tag, ".cnt"}, 32'(stall_cnt), 32'(exp_cnt));
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #3;
        chk("reset.ctrl", 32'(ctrl_vec), 32'(V_RST));
        chk("reset.cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        step("idle", V_RUN, 0);

        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
        step("lu_rs", V_LU, 1);
        ex_mem_read = 1'b0;
        step("lu_gone", V_RUN, 1);

        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
        step("reg0", V_RUN, 1);

        id_rs = 5'd3; ex_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b0;
        step("rt_unused", V_RUN, 1);
        id_uses_rt = 1'b1;
        step("rt_used", V_LU, 2);
        ex_branch_taken = 1'b1;
        step("br_over_lu", V_BR, 2);

        idle();
        mem_req = 1'b1;
        step("wait1", V_FROZE, 3);
        step("wait2", V_FROZE, 4);
        step("wait3", V_FROZE, 5);
        mem_ready = 1'b1;
        step("wait_done", V_RUN, 5);

        mem_ready = 1'b0;
        step("reenter", V_FROZE, 6);
        step("to2", V_FROZE, 7);
        step("to3", V_FROZE, 8);
        step("to4", V_FROZE, 9);
        step("to_err", V_ERR, 9);
        mem_req = 1'b0;
        step("after_err", V_RUN, 9);

        mem_req = 1'b1;
        step("w_lu1", V_FROZE, 10);
        mem_ready = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs = 5'd9;
        step("w_lu_exit", V_LU, 11);

        idle();
        mem_req = 1'b1;
        step("pre_rst", V_FROZE, 12);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid.ctrl", 32'(ctrl_vec), 32'(V_RST));
        chk("rst_mid.cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk); #1;
        chk("rst_hold.ctrl", 32'(ctrl_vec), 32'(V_RST));
        reset = 1'b0;
        mem_req = 1'b0;
        step("post_rst", V_RUN, 0);

        ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs = 5'd4;
        for (int i = 0; i < 17; i++) begin
            #3;
            @(posedge clk);
            #1;
        end
        chk("sat.cnt", 32'(stall_cnt), 32'd15);
        step("sat_hold", V_LU, 15);
        idle();
        step("sat_idle", V_RUN, 15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
